// File: rtl/scratch_ram128_pci.sv
// scratch_ram128_pci: 128-bit, 256 KiB scratchpad RAM slave with a PCI type-0
// configuration header. Config cycles program BAR0 and command; RAM accesses
// that hit BAR0 (with command[1] set) complete with a fixed-latency ack.
//
// Ports:
//   clk_i, rst_i           clock (rising edge), async active-low reset
//   cs_config_i, cs_ram_i  config-space / memory-space selects
//   cyc_i, stb_i, we_i     bus cycle, strobe, write enable
//   sel_i[15:0]            byte lane selects
//   adr_i[31:0]            byte address
//   dat_i[127:0]           write data
//   tid_i[7:0], cid_i[3:0] transaction / core tags
//   ack_o                  completion strobe (RAM: cycle 4, config: cycle 3)
//   next_o                 tied low
//   dat_o[127:0]           read data, zero outside read acks
//   tid_o, cid_o, adr_o    request tags delayed four clocks
module scratch_ram128_pci #(
    parameter logic [31:0] IO_ADDR                 = 32'hFFFC0001,
    parameter logic [31:0] IO_ADDR_MASK            = 32'h00FC0000,
    parameter logic [7:0]  CFG_BUS                 = 8'd0,
    parameter logic [4:0]  CFG_DEVICE              = 5'd11,
    parameter logic [2:0]  CFG_FUNC                = 3'd0,
    parameter logic [15:0] CFG_VENDOR_ID           = 16'h0,
    parameter logic [15:0] CFG_DEVICE_ID           = 16'h0,
    parameter logic [15:0] CFG_SUBSYSTEM_VENDOR_ID = 16'h0,
    parameter logic [15:0] CFG_SUBSYSTEM_ID        = 16'h0,
    parameter logic [31:0] CFG_ROM_ADDR            = 32'hFFFFFFF0,
    parameter logic [7:0]  CFG_REVISION_ID         = 8'd0,
    parameter logic [7:0]  CFG_PROGIF              = 8'd1,
    parameter logic [7:0]  CFG_SUBCLASS            = 8'h00,
    parameter logic [7:0]  CFG_CLASS               = 8'h05,
    parameter logic [7:0]  CFG_CACHE_LINE_SIZE     = 8'd8,
    parameter logic [7:0]  CFG_MIN_GRANT           = 8'h00,
    parameter logic [7:0]  CFG_MAX_LATENCY         = 8'h00,
    parameter logic [7:0]  CFG_IRQ_LINE            = 8'hFF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cs_config_i,
    input  logic         cs_ram_i,
    input  logic         cyc_i,
    input  logic         stb_i,
    input  logic         we_i,
    input  logic [15:0]  sel_i,
    input  logic [31:0]  adr_i,
    input  logic [127:0] dat_i,
    input  logic [7:0]   tid_i,
    input  logic [3:0]   cid_i,
    output logic         ack_o,
    output logic         next_o,
    output logic [127:0] dat_o,
    output logic [7:0]   tid_o,
    output logic [3:0]   cid_o,
    output logic [31:0]  adr_o
);

    localparam int unsigned DW        = 128;
    localparam int unsigned SW        = 16;
    localparam int unsigned RAM_DEPTH = 16384;
    localparam int unsigned RAM_AW    = 14;
    localparam int unsigned TAG_W     = 44;
    localparam int unsigned TAG_DEPTH = 4;

    // Request pipeline
    logic          cs_config_q;
    logic          csd_q;
    logic          cs_ram_q;
    logic [31:0]   adr_q1;
    logic [17:4]   adr_q2;
    logic          we_q1, we_q2;
    logic [SW-1:0] sel_q1, sel_q2;
    logic [DW-1:0] dat_q1, dat_q2;

    // Config registers
    logic [15:0]   command_q, command_d;
    logic [31:0]   bar0_q, bar0_d;
    logic [7:0]    irq_line_q, irq_line_d;

    // Ack pipeline
    logic          rd_ack_p_q, rd_ack_q;
    logic          cfg_rd_p_q, cfg_rd_ack_q;
    logic          wr_ack_p_q, wr_ack_q;

    logic [DW-1:0] cfg_word;
    logic [DW-1:0] cfg_rdat_q;
    logic [DW-1:0] ram_rd1_q, ram_rd2_q;
    logic [DW-1:0] mem [RAM_DEPTH];

    logic [TAG_W-1:0] tag_q [TAG_DEPTH];

    logic          cfg_hit;
    logic          bar0_hit;
    logic [SW-1:0] ram_be;
    logic [RAM_AW-1:0] ram_addr;

    // Bus/device/function decode of a configuration cycle
    assign cfg_hit = cs_config_i & cyc_i & stb_i
                   & (adr_i[27:20] == CFG_BUS)
                   & (adr_i[19:15] == CFG_DEVICE)
                   & (adr_i[14:12] == CFG_FUNC);

    // BAR0 decode on the once-registered address; memory decode must be enabled
    assign bar0_hit = (((adr_q1 ^ bar0_q) & IO_ADDR_MASK) == 32'h0) & command_q[1];

    assign ram_be   = {SW{we_q2}} & sel_q2;
    assign ram_addr = RAM_AW'(adr_q2[17:4]);

    // Request, decode and ack pipeline
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cs_config_q  <= 1'b0;
            csd_q        <= 1'b0;
            cs_ram_q     <= 1'b0;
            adr_q1       <= 32'h0;
            adr_q2       <= '0;
            we_q1        <= 1'b0;
            we_q2        <= 1'b0;
            sel_q1       <= '0;
            sel_q2       <= '0;
            dat_q1       <= '0;
            dat_q2       <= '0;
            rd_ack_p_q   <= 1'b0;
            rd_ack_q     <= 1'b0;
            cfg_rd_p_q   <= 1'b0;
            cfg_rd_ack_q <= 1'b0;
            wr_ack_p_q   <= 1'b0;
            wr_ack_q     <= 1'b0;
            cfg_rdat_q   <= '0;
        end else begin
            cs_config_q  <= cfg_hit;
            csd_q        <= cs_ram_i & cyc_i & stb_i;
            cs_ram_q     <= csd_q & bar0_hit;
            adr_q1       <= adr_i;
            adr_q2       <= adr_q1[17:4];
            we_q1        <= we_i;
            we_q2        <= we_q1;
            sel_q1       <= sel_i;
            sel_q2       <= sel_q1;
            dat_q1       <= dat_i;
            dat_q2       <= dat_q1;
            rd_ack_p_q   <= cs_ram_q & ~we_q2;
            rd_ack_q     <= rd_ack_p_q;
            cfg_rd_p_q   <= cs_config_q & ~we_q1;
            cfg_rd_ack_q <= cfg_rd_p_q;
            // Each select is paired with the we of its own pipeline stage
            wr_ack_p_q   <= (cs_ram_q & we_q2) | (cs_config_q & we_q1);
            wr_ack_q     <= wr_ack_p_q;
            if (cfg_rd_p_q) begin
                cfg_rdat_q <= cfg_word;
            end
        end
    end

    // Config register write decode; only header words 0..3 are writable
    always_comb begin
        logic [31:0] bar_wr;
        command_d  = command_q;
        bar0_d     = bar0_q;
        irq_line_d = irq_line_q;
        bar_wr     = bar0_q;
        if (cs_config_q && we_q1 && (adr_q1[11:6] == 6'd0)) begin
            case (adr_q1[5:4])
                2'd0: begin
                    for (int b = 0; b < 2; b++) begin
                        if (sel_q1[4 + b]) begin
                            command_d[8*b +: 8] = dat_q1[32 + 8*b +: 8];
                        end
                    end
                end
                2'd1: begin
                    for (int b = 0; b < 4; b++) begin
                        if (sel_q1[b]) begin
                            bar_wr[8*b +: 8] = dat_q1[8*b +: 8];
                        end
                    end
                    bar0_d = (bar0_q & ~IO_ADDR_MASK) | (bar_wr & IO_ADDR_MASK);
                end
                2'd3: begin
                    if (sel_q1[12]) begin
                        irq_line_d = dat_q1[103:96];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            command_q  <= 16'h0002;
            bar0_q     <= IO_ADDR;
            irq_line_q <= CFG_IRQ_LINE;
        end else begin
            command_q  <= command_d;
            bar0_q     <= bar0_d;
            irq_line_q <= irq_line_d;
        end
    end

    // Header read mux: four 128-bit words, dword 0 in the low lane
    always_comb begin
        cfg_word = '0;
        if (adr_q2[11:6] == 6'd0) begin
            case (adr_q2[5:4])
                2'd0: cfg_word = {8'h00, 8'h00, 8'h00, CFG_CACHE_LINE_SIZE,
                                  CFG_CLASS, CFG_SUBCLASS, CFG_PROGIF, CFG_REVISION_ID,
                                  16'h0, command_q,
                                  CFG_DEVICE_ID, CFG_VENDOR_ID};
                2'd1: cfg_word = {96'h0, bar0_q};
                2'd2: cfg_word = {CFG_SUBSYSTEM_ID, CFG_SUBSYSTEM_VENDOR_ID, 96'h0};
                default: cfg_word = {CFG_MAX_LATENCY, CFG_MIN_GRANT, 8'h00, irq_line_q,
                                     64'h0, CFG_ROM_ADDR};
            endcase
        end
    end

    // Byte-write RAM, read-first, two-register read latency; contents not reset
    always_ff @(posedge clk_i) begin
        if (cs_ram_q) begin
            ram_rd1_q <= mem[ram_addr];
            for (int b = 0; b < 16; b++) begin
                if (ram_be[b]) begin
                    mem[ram_addr][8*b +: 8] <= dat_q2[8*b +: 8];
                end
            end
        end
        ram_rd2_q <= ram_rd1_q;
    end

    // Tag delay line: three stages plus the output register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 4; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= {tid_i, cid_i, adr_i};
            for (int i = 1; i < 4; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tid_o  = tag_q[TAG_DEPTH-1][43:36];
    assign cid_o  = tag_q[TAG_DEPTH-1][35:32];
    assign adr_o  = tag_q[TAG_DEPTH-1][31:0];
    assign next_o = 1'b0;
    assign ack_o  = rd_ack_q | cfg_rd_ack_q | wr_ack_q;

    // Config read data takes priority over RAM data
    always_comb begin
        dat_o = '0;
        if (cfg_rd_ack_q) begin
            dat_o = cfg_rdat_q;
        end else if (rd_ack_q) begin
            dat_o = ram_rd2_q;
        end
    end

endmodule

// File: tb/tb_scratch_ram128_pci.sv
// Directed testbench for scratch_ram128_pci. Requests are launched on the
// falling edge; outputs are sampled on falling edges, so a request driven at
// falling edge 0 acks at falling edge 3 (config) or 4 (RAM).
module tb_scratch_ram128_pci;

    localparam int MAXQ = 8;
    localparam int MAXA = 16;
    localparam logic [31:0] CFG_BASE = 32'h0005_8000;   // bus 0, dev 11, fn 0

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         cs_config_i = 1'b0;
    logic         cs_ram_i = 1'b0;
    logic         cyc_i = 1'b0;
    logic         stb_i = 1'b0;
    logic         we_i = 1'b0;
    logic [15:0]  sel_i = '0;
    logic [31:0]  adr_i = '0;
    logic [127:0] dat_i = '0;
    logic [7:0]   tid_i = '0;
    logic [3:0]   cid_i = '0;
    logic         ack_o;
    logic         next_o;
    logic [127:0] dat_o;
    logic [7:0]   tid_o;
    logic [3:0]   cid_o;
    logic [31:0]  adr_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic         rq_cfg [MAXQ];
    logic         rq_ram [MAXQ];
    logic         rq_we  [MAXQ];
    logic [15:0]  rq_sel [MAXQ];
    logic [31:0]  rq_adr [MAXQ];
    logic [127:0] rq_dat [MAXQ];
    logic [7:0]   rq_tid [MAXQ];
    logic [3:0]   rq_cid [MAXQ];

    int           ak_n;
    int           ak_cyc [MAXA];
    logic [127:0] ak_dat [MAXA];
    logic [7:0]   ak_tid [MAXA];
    logic [3:0]   ak_cid [MAXA];
    logic [31:0]  ak_adr [MAXA];

    scratch_ram128_pci dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cs_config_i (cs_config_i),
        .cs_ram_i    (cs_ram_i),
        .cyc_i       (cyc_i),
        .stb_i       (stb_i),
        .we_i        (we_i),
        .sel_i       (sel_i),
        .adr_i       (adr_i),
        .dat_i       (dat_i),
        .tid_i       (tid_i),
        .cid_i       (cid_i),
        .ack_o       (ack_o),
        .next_o      (next_o),
        .dat_o       (dat_o),
        .tid_o       (tid_o),
        .cid_o       (cid_o),
        .adr_o       (adr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_req(input int i, input logic cfg, input logic ram, input logic we,
                           input logic [15:0] sel, input logic [31:0] adr,
                           input logic [127:0] dat, input logic [7:0] tid, input logic [3:0] cid);
        rq_cfg[i] = cfg; rq_ram[i] = ram; rq_we[i] = we; rq_sel[i] = sel;
        rq_adr[i] = adr; rq_dat[i] = dat; rq_tid[i] = tid; rq_cid[i] = cid;
    endtask

    task automatic drive_idle();
        cs_config_i = 1'b0; cs_ram_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        sel_i = '0; adr_i = '0; dat_i = '0; tid_i = '0; cid_i = '0;
    endtask

    task automatic drive_req(input int i);
        cs_config_i = rq_cfg[i]; cs_ram_i = rq_ram[i]; cyc_i = 1'b1; stb_i = 1'b1;
        we_i = rq_we[i]; sel_i = rq_sel[i]; adr_i = rq_adr[i]; dat_i = rq_dat[i];
        tid_i = rq_tid[i]; cid_i = rq_cid[i];
    endtask

    // Issues n requests on consecutive cycles, recording every ack seen in n+16 cycles
    task automatic run_burst(input int n);
        ak_n = 0;
        for (int c = 0; c < n + 16; c++) begin
            @(negedge clk_i);
            if (ack_o === 1'b1 && ak_n < MAXA) begin
                ak_cyc[ak_n] = c; ak_dat[ak_n] = dat_o; ak_tid[ak_n] = tid_o;
                ak_cid[ak_n] = cid_o; ak_adr[ak_n] = adr_o;
                ak_n++;
            end
            if (c < n) drive_req(c);
            else       drive_idle();
        end
    endtask

    task automatic single(input logic cfg, input logic ram, input logic we, input logic [15:0] sel,
                          input logic [31:0] adr, input logic [127:0] dat, input logic [7:0] tid);
        set_req(0, cfg, ram, we, sel, adr, dat, tid, 4'h0);
        run_burst(1);
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk_i);
        n_checks++; if (ack_o !== 1'b0) $display("FAIL reset_ack: got %b want 0", ack_o); else n_pass++;
        n_checks++; if (dat_o !== 128'h0) $display("FAIL reset_dat: got %h want 0", dat_o); else n_pass++;
        n_checks++; if (tid_o !== 8'h0) $display("FAIL reset_tid: got %h want 0", tid_o); else n_pass++;
        n_checks++; if (cid_o !== 4'h0) $display("FAIL reset_cid: got %h want 0", cid_o); else n_pass++;
        n_checks++; if (adr_o !== 32'h0) $display("FAIL reset_adr: got %h want 0", adr_o); else n_pass++;
        n_checks++; if (next_o !== 1'b0) $display("FAIL reset_next: got %b want 0", next_o); else n_pass++;
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_cfg_read();
        // Word 0, dword 2 holds the class code
        single(1'b1, 1'b0, 1'b0, 16'hFFFF, CFG_BASE | 32'h8, '0, 8'h01);
        n_checks++; if (ak_n != 1 || ak_cyc[0] != 3) $display("FAIL cfg_rd_lat: acks %0d at %0d want 1 at 3", ak_n, ak_cyc[0]); else n_pass++;
        n_checks++; if (ak_dat[0][95:64] !== 32'h05000100) $display("FAIL cfg_class: got %h want 05000100", ak_dat[0][95:64]); else n_pass++;
        n_checks++; if (ak_dat[0] !== 128'h00000008_05000100_00000002_00000000) $display("FAIL cfg_word0: got %h", ak_dat[0]); else n_pass++;
        single(1'b1, 1'b0, 1'b0, 16'hFFFF, CFG_BASE | 32'h10, '0, 8'h02);
        n_checks++; if (ak_n != 1 || ak_dat[0] !== 128'h00000000_00000000_00000000_FFFC0001) $display("FAIL cfg_word1: acks %0d got %h", ak_n, ak_dat[0]); else n_pass++;
        single(1'b1, 1'b0, 1'b0, 16'hFFFF, CFG_BASE | 32'h30, '0, 8'h03);
        n_checks++; if (ak_n != 1 || ak_dat[0] !== 128'h000000FF_00000000_00000000_FFFFFFF0) $display("FAIL cfg_word3: acks %0d got %h", ak_n, ak_dat[0]); else n_pass++;
        // Beyond the 64-byte header reads zero but still acks
        single(1'b1, 1'b0, 1'b0, 16'hFFFF, CFG_BASE | 32'h40, '0, 8'h04);
        n_checks++; if (ak_n != 1 || ak_cyc[0] != 3 || ak_dat[0] !== 128'h0) $display("FAIL cfg_outside: acks %0d at %0d got %h", ak_n, ak_cyc[0], ak_dat[0]); else n_pass++;
    endtask

    task automatic test_ram_write_read();
        single(1'b0, 1'b1, 1'b1, 16'hFFFF, 32'hFFFC0010, 128'hFFEEDDCC_BBAA9988_77665544_33221100, 8'h10);
        n_checks++; if (ak_n != 1 || ak_cyc[0] != 4) $display("FAIL ram_wr_full_lat: acks %0d at %0d want 1 at 4", ak_n, ak_cyc[0]); else n_pass++;
        single(1'b0, 1'b1, 1'b1, 16'h00FF, 32'hFFFC0010, 128'h01234567_89ABCDEF_01234567_89ABCDEF, 8'h11);
        n_checks++; if (ak_n != 1 || ak_cyc[0] != 4 || ak_dat[0] !== 128'h0) $display("FAIL ram_wr_part: acks %0d at %0d dat %h", ak_n, ak_cyc[0], ak_dat[0]); else n_pass++;
        single(1'b0, 1'b1, 1'b0, 16'hFFFF, 32'hFFFC0010, '0, 8'h12);
        n_checks++; if (ak_n != 1 || ak_cyc[0] != 4) $display("FAIL ram_rd_lat: acks %0d at %0d want 1 at 4", ak_n, ak_cyc[0]); else n_pass++;
        n_checks++; if (ak_dat[0] !== 128'hFFEEDDCC_BBAA9988_01234567_89ABCDEF) $display("FAIL ram_rd_bytes: got %h", ak_dat[0]); else n_pass++;
        n_checks++; if (ak_tid[0] !== 8'h12 || ak_adr[0] !== 32'hFFFC0010) $display("FAIL ram_rd_tags: tid %h adr %h want 12 fffc0010", ak_tid[0], ak_adr[0]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] d [4];
        d[0] = 128'hA0A0A0A0_00000000_11111111_00000000;
        d[1] = 128'hA1A1A1A1_00000001_22222222_00000001;
        d[2] = 128'hA2A2A2A2_00000002_33333333_00000002;
        d[3] = 128'hA3A3A3A3_00000003_44444444_00000003;
        for (int i = 0; i < 4; i++)
            set_req(i, 1'b0, 1'b1, 1'b1, 16'hFFFF, 32'hFFFC0100 + 32'(i * 16), d[i], 8'h20, 4'h0);
        run_burst(4);
        n_checks++; if (ak_n != 4 || ak_cyc[0] != 4 || ak_cyc[3] != 7) $display("FAIL b2b_writes: acks %0d first %0d last %0d", ak_n, ak_cyc[0], ak_cyc[3]); else n_pass++;
        for (int i = 0; i < 4; i++)
            set_req(i, 1'b0, 1'b1, 1'b0, 16'hFFFF, 32'hFFFC0100 + 32'(i * 16), '0, 8'(i + 1), 4'(i + 8));
        run_burst(4);
        n_checks++; if (ak_n != 4) $display("FAIL b2b_rd_count: got %0d want 4", ak_n); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ak_cyc[i] != 4 + i || ak_tid[i] !== 8'(i + 1) || ak_cid[i] !== 4'(i + 8) ||
                ak_adr[i] !== 32'hFFFC0100 + 32'(i * 16) || ak_dat[i] !== d[i])
                $display("FAIL b2b_rd%0d: cyc %0d tid %h cid %h adr %h dat %h want cyc %0d dat %h",
                         i, ak_cyc[i], ak_tid[i], ak_cid[i], ak_adr[i], ak_dat[i], 4 + i, d[i]);
            else n_pass++;
        end
        // Write then read of the same line on consecutive cycles
        set_req(0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 32'hFFFC0200, 128'hC0FFEE00_12345678_9ABCDEF0_0BADF00D, 8'h30, 4'h1);
        set_req(1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 32'hFFFC0200, '0, 8'h31, 4'h2);
        run_burst(2);
        n_checks++;
        if (ak_n != 2 || ak_cyc[1] != 5 || ak_dat[1] !== 128'hC0FFEE00_12345678_9ABCDEF0_0BADF00D)
            $display("FAIL wr_then_rd: acks %0d cyc %0d dat %h", ak_n, ak_cyc[1], ak_dat[1]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        set_req(0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 32'hFFFC0010, '0, 8'h5A, 4'h3);
        @(negedge clk_i); drive_req(0);
        @(negedge clk_i); drive_idle();
        repeat (3) @(negedge clk_i);
        n_checks++; if (ack_o !== 1'b1 || tid_o !== 8'h5A) $display("FAIL pre_reset_ack: ack %b tid %h want 1 5a", ack_o, tid_o); else n_pass++;
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (ack_o !== 1'b0 || dat_o !== 128'h0 || tid_o !== 8'h0 || adr_o !== 32'h0)
            $display("FAIL async_reset: ack %b dat %h tid %h adr %h want all 0", ack_o, dat_o, tid_o, adr_o);
        else n_pass++;
        @(negedge clk_i); rst_i = 1'b1;
        // Reset two cycles into a read: the read must vanish
        ak_n = 0;
        @(negedge clk_i); drive_req(0);
        @(negedge clk_i); drive_idle();
        @(negedge clk_i); rst_i = 1'b0;
        @(negedge clk_i); rst_i = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_i);
            if (ack_o === 1'b1) ak_n++;
        end
        n_checks++; if (ak_n != 0) $display("FAIL late_ack: got %0d acks want 0", ak_n); else n_pass++;
    endtask

    task automatic test_bar0();
        single(1'b1, 1'b0, 1'b1, 16'hFFFF, CFG_BASE | 32'h10, 128'h00000000_00000000_00000000_00400000, 8'h40);
        n_checks++; if (ak_n != 1 || ak_cyc[0] != 3) $display("FAIL cfg_wr_lat: acks %0d at %0d want 1 at 3", ak_n, ak_cyc[0]); else n_pass++;
        single(1'b1, 1'b0, 1'b0, 16'hFFFF, CFG_BASE | 32'h10, '0, 8'h41);
        n_checks++; if (ak_n != 1 || ak_dat[0] !== 128'h00000000_00000000_00000000_FF400001) $display("FAIL bar0_rb: got %h want ff400001", ak_dat[0]); else n_pass++;
        single(1'b0, 1'b1, 1'b1, 16'hFFFF, 32'hFF400020, 128'hE0E1E2E3_E4E5E6E7_E8E9EAEB_ECEDEEEF, 8'h42);
        single(1'b0, 1'b1, 1'b0, 16'hFFFF, 32'hFF400020, '0, 8'h43);
        n_checks++; if (ak_n != 1 || ak_cyc[0] != 4 || ak_dat[0] !== 128'hE0E1E2E3_E4E5E6E7_E8E9EAEB_ECEDEEEF) $display("FAIL new_base_rd: acks %0d dat %h", ak_n, ak_dat[0]); else n_pass++;
        single(1'b0, 1'b1, 1'b0, 16'hFFFF, 32'hFFFC0020, '0, 8'h44);
        n_checks++; if (ak_n != 0) $display("FAIL old_base_miss: got %0d acks want 0", ak_n); else n_pass++;
    endtask

    task automatic test_cmd_disable();
        single(1'b1, 1'b0, 1'b1, 16'h0030, CFG_BASE, '0, 8'h50);
        single(1'b1, 1'b0, 1'b0, 16'hFFFF, CFG_BASE, '0, 8'h51);
        n_checks++; if (ak_n != 1 || ak_dat[0] !== 128'h00000008_05000100_00000000_00000000) $display("FAIL cmd_clear_rb: got %h", ak_dat[0]); else n_pass++;
        single(1'b0, 1'b1, 1'b0, 16'hFFFF, 32'hFF400020, '0, 8'h52);
        n_checks++; if (ak_n != 0) $display("FAIL cmd_off_rd: got %0d acks want 0", ak_n); else n_pass++;
        single(1'b0, 1'b1, 1'b1, 16'hFFFF, 32'hFF400020, 128'h0, 8'h53);
        n_checks++; if (ak_n != 0) $display("FAIL cmd_off_wr: got %0d acks want 0", ak_n); else n_pass++;
        // Re-enable memory decode; the dropped write must not have landed
        single(1'b1, 1'b0, 1'b1, 16'h0030, CFG_BASE, 128'h00000000_00000000_00000002_00000000, 8'h54);
        single(1'b0, 1'b1, 1'b0, 16'hFFFF, 32'hFF400020, '0, 8'h55);
        n_checks++; if (ak_n != 1 || ak_dat[0] !== 128'hE0E1E2E3_E4E5E6E7_E8E9EAEB_ECEDEEEF) $display("FAIL dropped_wr: acks %0d dat %h", ak_n, ak_dat[0]); else n_pass++;
        single(1'b1, 1'b0, 1'b0, 16'hFFFF, 32'h0006_0000, '0, 8'h56);
        n_checks++; if (ak_n != 0) $display("FAIL wrong_device: got %0d acks want 0", ak_n); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_cfg_read();
        test_ram_write_read();
        test_back_to_back();
        test_reset_mid_read();
        test_bar0();
        test_cmd_disable();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
